// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the cpu front-end: datapath width, the default reset
// fetch address, the NOP that decode substitutes while fetch has nothing valid,
// and the layout of a fetch entry as carried from fetch to decode.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    // A fetch entry is the concatenation {pc, instr}; pc occupies the upper
    // half so that a packed entry can be sliced the same way everywhere.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with a single-cycle flush, used as the prefetch buffer
// between instruction memory and decode. Writes land at the tail on the clock
// edge; the head is read combinationally (no write-to-read bypass).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (empties the FIFO)
//   flush      empties the FIFO on the next edge; wins over push and pop
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        advance the head (ignored when empty)
//   head_data  entry at the head (meaningful only when !empty)
//   count      number of stored entries
//   full       count == DEPTH
//   empty      count == 0
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front-end. Issues sequential word fetches to instruction
// memory under a credit limit, buffers returned words with their PCs in a
// prefetch FIFO and hands {pc, instr} to decode. A redirect flushes the FIFO,
// restarts fetch at the (word-aligned) target and discards every response that
// belongs to requests issued before the redirect.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_resp_valid/data             in-order response channel (no backpressure)
//   redirect_valid/pc                branch/jump redirect from execute
//   if_valid/ready, if_pc, if_instr  head of the prefetch FIFO toward decode
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN       = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = 2 * XLEN;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Wraps modulo 2^XLEN: the last word address is followed by zero.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(4);
    endfunction

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   head_entry;

    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            resp_drop;
    logic            resp_keep;
    logic            pop;

    assign redirect_target = align_word(redirect_pc);

    // Entries already buffered plus requests still in flight may never exceed
    // the FIFO size, so every response is guaranteed a slot when it arrives.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle is stale by definition; otherwise it is
    // stale while drop_cnt still counts pre-redirect requests.
    assign resp_drop = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
    assign resp_keep = imem_resp_valid && !resp_drop;

    assign if_valid = !reset && !fifo_empty;
    assign pop      = if_valid && if_ready;
    assign if_pc    = reset ? '0 : head_entry[EW-1:XLEN];
    assign if_instr = reset ? '0 : head_entry[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({req_fire, imem_resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                // No request fires in this cycle, so everything still
                // outstanding (minus the one responding now) is stale.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire)  fetch_pc <= next_word(fetch_pc);
                if (resp_keep) resp_pc  <= next_word(resp_pc);
                if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (resp_keep),
        .push_data ({resp_pc, imem_resp_data}),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credit_used <= CREDIT_MAX);

    a_resp_has_req: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (outstanding != '0));

    a_keep_has_room: assert property (@(posedge clk) disable iff (reset)
        !(resp_keep && fifo_full));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end directly upstream of the cpu decode/execute path.
- Generates sequential PCs and issues requests to instruction memory, which has valid/ready request and in-order response channels.
- Buffers returned words in a small prefetch FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles redirects from branches and jumps by flushing the FIFO and discarding in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2; also the cap on outstanding requests.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  word-aligned fetch address
- imem_resp_valid  input  1  response word valid; in order, exactly one per accepted request, at least 1 cycle after acceptance
- imem_resp_data  input  XLEN  instruction word
- redirect_valid  input  1  redirect request from the execute stage
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored and forced to 0
- if_valid  output  1  FIFO head valid toward decode
- if_ready  input  1  decode accepts head
- if_pc  output  XLEN  PC of head entry
- if_instr  output  XLEN  instruction of head entry

Behaviour:
- Reset, applied at a clock edge while reset=1:
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0 while reset is high.
- Reset mid-operation discards all state. Responses arriving after reset for pre-reset requests are not tolerated: the memory is reset together with this block.
- Credit rule:
  - imem_req_valid = !reset && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
- Request accepted when imem_req_valid && imem_req_ready: outstanding+1, fetch_pc+=4, wrapping modulo 2^XLEN. 32'hFFFF_FFFC is followed by 0.
- Response handling:
  - If drop_cnt>0: response discarded, drop_cnt-1, outstanding-1.
  - Otherwise: written to the FIFO tail with its pc, outstanding-1.
  - The pc is tracked by a separate resp_pc register: set on redirect or reset, +4 per kept response.
  - Credit guarantees the FIFO never overflows; overflow is an assertion failure.
- Latency: no bypass. A response written at edge N is visible on if_valid after edge N. With 1-cycle memory and ready=1, the first if_valid is 2 cycles after reset deasserts.
- Decode handshake: head popped when if_valid && if_ready. if_pc and if_instr hold stable while if_valid && !if_ready.
- Redirect, on the edge where redirect_valid=1:
  - FIFO flushed, including any entry popped that same cycle; the pop still counts as consumed.
  - fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding − (imem_resp_valid ? 1 : 0). A response in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - if_valid=0 the next cycle.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each cycle.
- Simultaneous push and pop on a full FIFO is not possible: credit reserves the space. Push and pop in the same cycle on a non-empty FIFO keeps fifo_count unchanged.
- Counters are sized $clog2(FIFO_DEPTH)+1 bits. outstanding + fifo_count ≤ FIFO_DEPTH always; this is asserted.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN.
  - RESET_PC default.
  - INSTR_NOP = 32'h0000_0013, used by decode when !if_valid.
  - The fetch entry struct/concat layout {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO with flush, parameterised width and depth, exposing count/full/empty. All PC, credit and drop logic stays in fetch_unit.

Test Plan:
- Reset release, 1-cycle memory, if_ready=1 → requests at 0x0, 0x4, 0x8…; if_valid first high 2 cycles after reset low with if_pc=0; then one instruction per cycle.
- if_ready=0 for 10 cycles → exactly FIFO_DEPTH=2 requests issued, imem_req_valid then stays 0; head holds pc=0 and instr stable; on release, pcs 0, 4, 8 in order with no gaps.
- 2 requests outstanding (3-cycle memory), redirect to 0x100 → both stale responses dropped; next if_pc=0x100 with the 0x100 word; no stale pc ever presented.
- Redirect with redirect_pc=0x203 in the same cycle as a response and a decode pop → FIFO empty next cycle; fetch resumes at 0x200; the coincident response is discarded.
- RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc wraps identically.
- imem_req_ready random 50% plus random if_ready, 1000 cycles against a scoreboard model → in-order pcs, no loss or duplication, and the outstanding + count ≤ 2 assertion never fires.
